// File: rtl/reset_sequencer.sv
// Staged reset sequencer: turns one synchronous system reset into N_CH
// active-low channel resets. All channels are held for HOLD_CYC cycles, then
// released in order STAGE_CYC cycles apart. Software requests and a heartbeat
// watchdog can restart the whole sequence, and such restarts are counted.
module reset_sequencer #(
  parameter int N_CH      = 3,
  parameter int HOLD_CYC  = 16,
  parameter int STAGE_CYC = 8,
  parameter int WDT_CYC   = 1024,
  parameter int CNT_W     = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             sw_rst_req,
  input  logic             heartbeat,
  input  logic             wdt_en,
  output logic [N_CH-1:0]  ch_rst_n,
  output logic             all_released,
  output logic             wdt_fired,
  output logic [CNT_W-1:0] reboot_cnt,
  output logic [1:0]       state
);

  // Counters only need to reach CYC-1; the terminal edge acts on that value.
  localparam int HOLD_W  = (HOLD_CYC  > 1) ? $clog2(HOLD_CYC)  : 1;
  localparam int STAGE_W = (STAGE_CYC > 1) ? $clog2(STAGE_CYC) : 1;
  localparam int WDT_W   = $clog2(WDT_CYC);

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYC - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(STAGE_CYC - 1);
  localparam logic [WDT_W-1:0]   WDT_LAST   = WDT_W'(WDT_CYC - 1);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_STAGE = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t             state_reg;
  state_t             state_nxt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [HOLD_W-1:0]  hold_cnt_nxt;
  logic [STAGE_W-1:0] stage_cnt;
  logic [STAGE_W-1:0] stage_cnt_nxt;
  logic [WDT_W-1:0]   wdt_cnt;
  logic [WDT_W-1:0]   wdt_cnt_nxt;
  logic [N_CH-1:0]    ch_rst_n_nxt;
  logic [N_CH-1:0]    ch_shift;
  logic               all_released_nxt;
  logic               wdt_fired_nxt;
  logic [CNT_W-1:0]   reboot_cnt_nxt;
  logic               sw_req_prev;

  // The reboot counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign state    = state_reg;
  // Releasing the next channel shifts a one in from the bottom, so channel 0
  // is always released first and released channels stay released.
  assign ch_shift = (ch_rst_n << 1) | N_CH'(1);

  // Register every output and counter; system reset overrides everything.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg    <= ST_HOLD;
      hold_cnt     <= '0;
      stage_cnt    <= '0;
      wdt_cnt      <= '0;
      ch_rst_n     <= '0;
      all_released <= 1'b0;
      wdt_fired    <= 1'b0;
      reboot_cnt   <= '0;
      sw_req_prev  <= 1'b0;
    end else begin
      state_reg    <= state_nxt;
      hold_cnt     <= hold_cnt_nxt;
      stage_cnt    <= stage_cnt_nxt;
      wdt_cnt      <= wdt_cnt_nxt;
      ch_rst_n     <= ch_rst_n_nxt;
      all_released <= all_released_nxt;
      wdt_fired    <= wdt_fired_nxt;
      reboot_cnt   <= reboot_cnt_nxt;
      sw_req_prev  <= sw_rst_req;
    end
  end

  // Next-state and output logic; software request outranks all FSM activity.
  always_comb begin
    state_nxt        = state_reg;
    hold_cnt_nxt     = hold_cnt;
    stage_cnt_nxt    = stage_cnt;
    wdt_cnt_nxt      = wdt_cnt;
    ch_rst_n_nxt     = ch_rst_n;
    all_released_nxt = all_released;
    wdt_fired_nxt    = 1'b0;
    reboot_cnt_nxt   = reboot_cnt;

    if (sw_rst_req) begin
      // A held request pins the hold counter at zero; only the rising edge
      // of the request is counted as a reboot.
      state_nxt        = ST_HOLD;
      hold_cnt_nxt     = '0;
      stage_cnt_nxt    = '0;
      wdt_cnt_nxt      = '0;
      ch_rst_n_nxt     = '0;
      all_released_nxt = 1'b0;
      if (!sw_req_prev) begin
        reboot_cnt_nxt = sat_inc(reboot_cnt);
      end
    end else begin
      case (state_reg)
        ST_HOLD: begin
          ch_rst_n_nxt     = '0;
          all_released_nxt = 1'b0;
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt_nxt  = '0;
            stage_cnt_nxt = '0;
            wdt_cnt_nxt   = '0;
            ch_rst_n_nxt  = N_CH'(1);
            if (N_CH == 1) begin
              state_nxt        = ST_RUN;
              all_released_nxt = 1'b1;
            end else begin
              state_nxt = ST_STAGE;
            end
          end else begin
            hold_cnt_nxt = hold_cnt + HOLD_W'(1);
          end
        end

        ST_STAGE: begin
          if (stage_cnt == STAGE_LAST) begin
            stage_cnt_nxt = '0;
            ch_rst_n_nxt  = ch_shift;
            // The last channel goes out on the same edge that enters RUN.
            if (&ch_shift) begin
              state_nxt        = ST_RUN;
              all_released_nxt = 1'b1;
              wdt_cnt_nxt      = '0;
            end
          end else begin
            stage_cnt_nxt = stage_cnt + STAGE_W'(1);
          end
        end

        ST_RUN: begin
          // A heartbeat always clears the count, even on the would-be
          // timeout edge; a disabled watchdog freezes the count.
          if (heartbeat) begin
            wdt_cnt_nxt = '0;
          end else if (wdt_en) begin
            if (wdt_cnt == WDT_LAST) begin
              wdt_fired_nxt    = 1'b1;
              reboot_cnt_nxt   = sat_inc(reboot_cnt);
              state_nxt        = ST_HOLD;
              hold_cnt_nxt     = '0;
              stage_cnt_nxt    = '0;
              wdt_cnt_nxt      = '0;
              ch_rst_n_nxt     = '0;
              all_released_nxt = 1'b0;
            end else begin
              wdt_cnt_nxt = wdt_cnt + WDT_W'(1);
            end
          end
        end

        default: begin
          // Unused encoding: drop back into a clean hold.
          state_nxt        = ST_HOLD;
          hold_cnt_nxt     = '0;
          stage_cnt_nxt    = '0;
          wdt_cnt_nxt      = '0;
          ch_rst_n_nxt     = '0;
          all_released_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default-parameter instance for bring-up,
// software reset and watchdog timing, plus a small instance (one channel,
// short hold, 4-cycle watchdog, 2-bit reboot counter) for saturation and
// same-edge priority cases.
module tb_reset_sequencer;

  logic       clk;
  logic       rst, sw, hb, en;
  logic [2:0] ch;
  logic       all_rel, fired;
  logic [7:0] rb;
  logic [1:0] st;

  logic       s_rst, s_sw, s_hb, s_en;
  logic [0:0] s_ch;
  logic       s_all, s_fired;
  logic [1:0] s_rb;
  logic [1:0] s_st;

  int checks = 0;
  int errors = 0;

  reset_sequencer u_dut (
    .sys_clk      (clk),
    .sys_rst      (rst),
    .sw_rst_req   (sw),
    .heartbeat    (hb),
    .wdt_en       (en),
    .ch_rst_n     (ch),
    .all_released (all_rel),
    .wdt_fired    (fired),
    .reboot_cnt   (rb),
    .state        (st)
  );

  reset_sequencer #(
    .N_CH      (1),
    .HOLD_CYC  (2),
    .STAGE_CYC (1),
    .WDT_CYC   (4),
    .CNT_W     (2)
  ) u_small (
    .sys_clk      (clk),
    .sys_rst      (s_rst),
    .sw_rst_req   (s_sw),
    .heartbeat    (s_hb),
    .wdt_en       (s_en),
    .ch_rst_n     (s_ch),
    .all_released (s_all),
    .wdt_fired    (s_fired),
    .reboot_cnt   (s_rb),
    .state        (s_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       sw;
    int         n;
    logic [2:0] ch;
    logic       all;
    logic [1:0] st;
    logic       fired;
    logic [7:0] rb;
  } vec_t;

  vec_t tbl[$];

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    logic seen_fire;
    logic ch_bad;
    logic [1:0] exp_rb;

    rst = 1'b1; sw = 1'b0; hb = 1'b0; en = 1'b0;
    s_rst = 1'b1; s_sw = 1'b0; s_hb = 1'b0; s_en = 1'b0;

    // Bring-up with defaults, then software reset at edge 20.
    //             rst   sw    n   ch      all   st    fired rb
    tbl.push_back('{1'b1, 1'b0, 3,  3'b000, 1'b0, 2'd0, 1'b0, 8'd0});
    tbl.push_back('{1'b0, 1'b0, 1,  3'b000, 1'b0, 2'd0, 1'b0, 8'd0});
    tbl.push_back('{1'b0, 1'b0, 14, 3'b000, 1'b0, 2'd0, 1'b0, 8'd0});
    tbl.push_back('{1'b0, 1'b0, 1,  3'b001, 1'b0, 2'd1, 1'b0, 8'd0});
    tbl.push_back('{1'b0, 1'b0, 7,  3'b001, 1'b0, 2'd1, 1'b0, 8'd0});
    tbl.push_back('{1'b0, 1'b0, 1,  3'b011, 1'b0, 2'd1, 1'b0, 8'd0});
    tbl.push_back('{1'b0, 1'b0, 7,  3'b011, 1'b0, 2'd1, 1'b0, 8'd0});
    tbl.push_back('{1'b0, 1'b0, 1,  3'b111, 1'b1, 2'd2, 1'b0, 8'd0});
    tbl.push_back('{1'b1, 1'b0, 1,  3'b000, 1'b0, 2'd0, 1'b0, 8'd0});
    tbl.push_back('{1'b0, 1'b0, 19, 3'b001, 1'b0, 2'd1, 1'b0, 8'd0});
    tbl.push_back('{1'b0, 1'b1, 1,  3'b000, 1'b0, 2'd0, 1'b0, 8'd1});
    tbl.push_back('{1'b0, 1'b1, 4,  3'b000, 1'b0, 2'd0, 1'b0, 8'd1});
    tbl.push_back('{1'b0, 1'b0, 1,  3'b000, 1'b0, 2'd0, 1'b0, 8'd1});
    tbl.push_back('{1'b0, 1'b0, 14, 3'b000, 1'b0, 2'd0, 1'b0, 8'd1});
    tbl.push_back('{1'b0, 1'b0, 1,  3'b001, 1'b0, 2'd1, 1'b0, 8'd1});
    tbl.push_back('{1'b0, 1'b0, 8,  3'b011, 1'b0, 2'd1, 1'b0, 8'd1});
    tbl.push_back('{1'b0, 1'b0, 8,  3'b111, 1'b1, 2'd2, 1'b0, 8'd1});

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst;
      sw  = tbl[i].sw;
      tick(tbl[i].n);
      chk($sformatf("vec%0d_ch", i),    32'(ch),      32'(tbl[i].ch));
      chk($sformatf("vec%0d_all", i),   32'(all_rel), 32'(tbl[i].all));
      chk($sformatf("vec%0d_state", i), 32'(st),      32'(tbl[i].st));
      chk($sformatf("vec%0d_fired", i), 32'(fired),   32'(tbl[i].fired));
      chk($sformatf("vec%0d_reboot", i), 32'(rb),     32'(tbl[i].rb));
    end

    // Regular heartbeat keeps the watchdog quiet.
    en = 1'b1;
    seen_fire = 1'b0;
    ch_bad = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      hb = (i % 100 == 0);
      tick(1);
      seen_fire |= fired;
      ch_bad |= (ch !== 3'b111);
    end
    hb = 1'b0;
    chk("hb_no_fire", 32'(seen_fire), 32'd0);
    chk("hb_ch_held", 32'(ch_bad), 32'd0);

    // Heartbeat absent from RUN entry: fire exactly WDT_CYC edges later.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(32);
    chk("wdt_run_entry", 32'(st), 32'd2);
    seen_fire = 1'b0;
    for (int i = 0; i < 1023; i++) begin
      tick(1);
      seen_fire |= fired;
    end
    chk("wdt_early", 32'(seen_fire), 32'd0);
    tick(1);
    chk("wdt_fire", 32'(fired), 32'd1);
    chk("wdt_fire_ch", 32'(ch), 32'd0);
    chk("wdt_fire_state", 32'(st), 32'd0);
    chk("wdt_fire_all", 32'(all_rel), 32'd0);
    chk("wdt_fire_reboot", 32'(rb), 32'd1);
    tick(1);
    chk("wdt_pulse_len", 32'(fired), 32'd0);
    tick(14);
    chk("wdt_reseq_hold", 32'(ch), 32'd0);
    tick(1);
    chk("wdt_reseq_ch0", 32'(ch), 32'b001);
    tick(16);
    chk("wdt_reseq_all", 32'(ch), 32'b111);
    chk("wdt_reseq_state", 32'(st), 32'd2);

    // Watchdog disabled: never fires.
    en = 1'b0;
    seen_fire = 1'b0;
    ch_bad = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      tick(1);
      seen_fire |= fired;
      ch_bad |= (ch !== 3'b111);
    end
    chk("wdt_dis_no_fire", 32'(seen_fire), 32'd0);
    chk("wdt_dis_ch", 32'(ch_bad), 32'd0);

    // Disabling the watchdog freezes the count rather than clearing it.
    en = 1'b1;
    tick(1000);
    en = 1'b0;
    tick(100);
    en = 1'b1;
    tick(23);
    chk("wdt_hold_early", 32'(fired), 32'd0);
    tick(1);
    chk("wdt_hold_fire", 32'(fired), 32'd1);
    chk("wdt_hold_reboot", 32'(rb), 32'd2);
    tick(32);
    chk("wdt_hold_rerun", 32'(st), 32'd2);

    // One-cycle system reset in RUN clears everything, including reboots.
    rst = 1'b1;
    tick(1);
    chk("pulse_rst_ch", 32'(ch), 32'd0);
    chk("pulse_rst_reboot", 32'(rb), 32'd0);
    chk("pulse_rst_state", 32'(st), 32'd0);
    rst = 1'b0;
    tick(15);
    chk("pulse_rst_e15", 32'(ch), 32'd0);
    tick(1);
    chk("pulse_rst_e16", 32'(ch), 32'b001);

    // Small instance: five timeouts saturate a 2-bit reboot counter.
    s_rst = 1'b1;
    tick(1);
    chk("s_reset_state", 32'(s_st), 32'd0);
    s_rst = 1'b0;
    s_en = 1'b1;
    tick(1);
    chk("s_e1_ch", 32'(s_ch), 32'd0);
    tick(1);
    chk("s_e2_ch", 32'(s_ch), 32'd1);
    chk("s_e2_all", 32'(s_all), 32'd1);
    chk("s_e2_state", 32'(s_st), 32'd2);
    for (int k = 1; k <= 5; k++) begin
      exp_rb = (k < 3) ? 2'(k) : 2'd3;
      tick(3);
      chk($sformatf("s_to%0d_early", k), 32'(s_fired), 32'd0);
      tick(1);
      chk($sformatf("s_to%0d_fire", k), 32'(s_fired), 32'd1);
      chk($sformatf("s_to%0d_reboot", k), 32'(s_rb), 32'(exp_rb));
      chk($sformatf("s_to%0d_ch", k), 32'(s_ch), 32'd0);
      tick(2);
      chk($sformatf("s_to%0d_rerun", k), 32'(s_st), 32'd2);
    end

    // Software request on the timeout edge: no fire, one increment.
    s_rst = 1'b1;
    tick(1);
    s_rst = 1'b0;
    tick(2);
    chk("s_co_run", 32'(s_st), 32'd2);
    chk("s_co_rb0", 32'(s_rb), 32'd0);
    tick(3);
    chk("s_co_early", 32'(s_fired), 32'd0);
    s_sw = 1'b1;
    tick(1);
    chk("s_co_fired", 32'(s_fired), 32'd0);
    chk("s_co_reboot", 32'(s_rb), 32'd1);
    chk("s_co_state", 32'(s_st), 32'd0);
    s_sw = 1'b0;
    tick(1);
    chk("s_co_reboot2", 32'(s_rb), 32'd1);
    chk("s_co_fired2", 32'(s_fired), 32'd0);
    tick(1);
    chk("s_co_rerun", 32'(s_st), 32'd2);

    // Heartbeat on the would-be timeout edge wins.
    tick(3);
    s_hb = 1'b1;
    tick(1);
    chk("s_hb_win_fired", 32'(s_fired), 32'd0);
    chk("s_hb_win_state", 32'(s_st), 32'd2);
    s_hb = 1'b0;
    tick(3);
    chk("s_hb_after_early", 32'(s_fired), 32'd0);
    tick(1);
    chk("s_hb_after_fire", 32'(s_fired), 32'd1);
    chk("s_hb_after_reboot", 32'(s_rb), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised successor to the single-reset SoC bring-up: generates N_CH staged, active-low core/peripheral resets from one synchronous system reset.
- Adds a minimum hold time, ordered per-channel release, software reset request, and a heartbeat watchdog that re-sequences a hung core.
- Sits between the board/bench reset source and the mips core plus its peripherals.
- Synthesisable; the same block is used in simulation and on FPGA.

Parameters:
- N_CH, 3: number of reset channels, >=1; channel 0 is released first.
- HOLD_CYC, 16: cycles all channels are held in reset after each reset cause ends; >=1.
- STAGE_CYC, 8: cycles between consecutive channel releases; >=1.
- WDT_CYC, 1024: consecutive RUN cycles without heartbeat before the watchdog fires; >=2.
- CNT_W, 8: width of the reboot counter.

Ports:
- sys_clk, in, 1: system clock; all logic is on the rising edge.
- sys_rst, in, 1: synchronous, active-high reset.
- sw_rst_req, in, 1: level software reset request.
- heartbeat, in, 1: core-alive pulse, e.g. instruction retire.
- wdt_en, in, 1: watchdog enable.
- ch_rst_n, out, N_CH: per-channel reset, active low.
- all_released, out, 1: high in RUN.
- wdt_fired, out, 1: one-cycle pulse when the watchdog times out.
- reboot_cnt, out, CNT_W: saturating count of software and watchdog reboots.
- state, out, 2: current state; HOLD=0, STAGE=1, RUN=2.

Behaviour:
- All outputs are registered.
- sys_rst=1 sampled at an edge forces the following on that edge:
  - state=HOLD, ch_rst_n=0, all_released=0, wdt_fired=0, reboot_cnt=0.
  - hold, stage and watchdog counters cleared.
- sys_rst has priority over every other input, in any state.
- Edge numbering: edge 1 is the first edge sampling sys_rst=0.
- HOLD:
  - Counts HOLD_CYC edges.
  - At edge HOLD_CYC: ch_rst_n[0]<=1 and state<=STAGE, or state<=RUN if N_CH=1.
- STAGE:
  - ch_rst_n[k]<=1 at edge HOLD_CYC + k*STAGE_CYC, for k=1..N_CH-1.
  - Released channels stay at 1 until the next HOLD.
  - Release of channel N_CH-1 happens on the same edge as state<=RUN and all_released<=1.
- RUN, watchdog:
  - Watchdog counter is 0 on entry to RUN.
  - Counter clears on any edge sampling heartbeat=1.
  - Otherwise it increments while wdt_en=1, and holds (does not clear) while wdt_en=0.
  - The edge that would make the count equal WDT_CYC does the following:
    - wdt_fired<=1 for one cycle.
    - reboot_cnt increments.
    - state<=HOLD, ch_rst_n<=0, all_released<=0, hold counter cleared.
  - So wdt_fired occurs after WDT_CYC consecutive enabled, heartbeat-free RUN edges.
- Simultaneous heartbeat and timeout: heartbeat wins, no fire.
- heartbeat is ignored outside RUN.
- sw_rst_req=1 sampled in any state (sys_rst=0):
  - state<=HOLD, ch_rst_n<=0, all_released<=0, counters cleared.
  - reboot_cnt increments once per rising request, detected against a registered previous value.
  - Holding sw_rst_req high keeps the hold counter at 0; the HOLD_CYC count starts on the first edge sampling sw_rst_req=0.
- sw_rst_req and watchdog timeout on the same edge: software reset wins, wdt_fired=0, reboot_cnt increments exactly once.
- reboot_cnt saturates at 2^CNT_W-1; it is never wrapped.
- Reset mid-STAGE or mid-RUN from any cause restarts the full HOLD then STAGE sequence.
- Illegal state encoding (3) goes to HOLD on the next edge.

Test Plan:
- Defaults, sys_rst high 3 edges then low:
  - ch_rst_n = 000 until edge 16, then 001, then 011 at edge 24, then 111 at edge 32.
  - all_released=1 and state=2 at edge 32; reboot_cnt=0.
- wdt_en=1, heartbeat pulse every 100 cycles for 5000 cycles in RUN -> wdt_fired never 1, ch_rst_n stays 111.
- heartbeat stopped from RUN entry:
  - wdt_fired pulses exactly 1024 edges later; ch_rst_n=000 on the same edge; reboot_cnt=1.
  - Full resequence follows: 001 after 16 edges, 111 after 32.
  - With wdt_en=0 instead, no fire over 5000 cycles.
- sw_rst_req high 5 cycles at edge 20 (ch_rst_n=001):
  - ch_rst_n=000 from edge 20.
  - ch_rst_n[0] rises 16 edges after the first edge sampling sw_rst_req=0; reboot_cnt=1.
- CNT_W=2, WDT_CYC=4, no heartbeat:
  - Five timeouts -> reboot_cnt = 1,2,3,3,3.
  - Timeout coinciding with sw_rst_req -> wdt_fired=0, single increment.
- sys_rst pulsed 1 cycle in RUN with reboot_cnt=2 -> next edge: ch_rst_n=000, reboot_cnt=0, state=0; release again at edge 16.
